// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, framed by sframe, with done on the last bit.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    output logic             d_ready,
    output logic             sout,
    output logic             sframe,
    output logic             done,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             sout_r, sout_s;
    logic             sframe_r, sframe_s;
    logic             done_r, done_s;
    logic             last_s;
    logic             accept_s;

    // The shift register keeps the bit currently on sout in its leading position.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-2] : w[1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_s   = (state_r == SHIFT) && (cnt_r == LAST_CNT);
    assign d_ready  = (state_r == IDLE) || last_s;
    assign accept_s = d_valid && d_ready;
    assign sout     = sout_r;
    assign sframe   = sframe_r;
    assign done     = done_r;
    assign busy     = (state_r == SHIFT);

    // Next-state and next-output decode; an accept always reloads the word.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        sout_s   = sout_r;
        sframe_s = sframe_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE, SHIFT: begin
                if (accept_s) begin
                    state_s  = SHIFT;
                    shreg_s  = d;
                    cnt_s    = {CW{1'b0}};
                    sout_s   = first_bit(d);
                    sframe_s = 1'b1;
                    done_s   = 1'b0;
                end else if (state_r == SHIFT && !last_s) begin
                    state_s  = SHIFT;
                    shreg_s  = shift_word(shreg_r);
                    cnt_s    = cnt_r + CW'(1);
                    sout_s   = next_bit(shreg_r);
                    sframe_s = 1'b1;
                    done_s   = (cnt_r == PRE_LAST);
                end else begin
                    state_s  = IDLE;
                    sout_s   = IDLE_LEVEL;
                    sframe_s = 1'b0;
                    done_s   = 1'b0;
                end
            end
            default: begin
                state_s  = IDLE;
                sout_s   = IDLE_LEVEL;
                sframe_s = 1'b0;
                done_s   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered serial outputs; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            sout_r   <= IDLE_LEVEL;
            sframe_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            sout_r   <= sout_s;
            sframe_r <= sframe_s;
            done_r   <= done_s;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: an MSB-first instance with idle level 0
// and an LSB-first instance with idle level 1.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic       d_valid, d_ready, sout, sframe, done, busy;
    logic [3:0] d;
    logic       d_valid2, d_ready2, sout2, sframe2, done2, busy2;
    logic [3:0] d2;

    int checks   = 0;
    int failures = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d(d), .d_ready(d_ready),
        .sout(sout), .sframe(sframe), .done(done), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut2 (
        .clk(clk), .reset(reset), .d_valid(d_valid2), .d(d2), .d_ready(d_ready2),
        .sout(sout2), .sframe(sframe2), .done(done2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({sout, sframe, done, busy, d_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL %s idle: got sout/sframe/done/busy/d_ready=%b expected 00001", tag,
                     {sout, sframe, done, busy, d_ready});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        check_idle("reset");
        checks++;
        if ({sout2, sframe2, done2, busy2, d_ready2} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_dut2: got %b expected 10001",
                     {sout2, sframe2, done2, busy2, d_ready2});
        end
        reset = 1'b0;
        step();
        check_idle("post_reset");
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;
        d = 4'b1010;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sframe, done, busy} !== {exp_bits[3 - i], 1'b1, (i == 3), 1'b1}) begin
                failures++;
                $display("FAIL single bit%0d: got sout/sframe/done/busy=%b expected %b", i,
                         {sout, sframe, done, busy}, {exp_bits[3 - i], 1'b1, (i == 3), 1'b1});
            end
            step();
        end
        check_idle("single_end");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b00111100;
        d = 4'b0011;
        d_valid = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({sout, sframe, done} !== {exp_bits[7 - i], 1'b1, (i == 3 || i == 7)}) begin
                failures++;
                $display("FAIL b2b bit%0d: got sout/sframe/done=%b expected %b", i,
                         {sout, sframe, done}, {exp_bits[7 - i], 1'b1, (i == 3 || i == 7)});
            end
            if (i == 3) d = 4'b1100;
            if (i == 7) d_valid = 1'b0;
            step();
        end
        check_idle("b2b_end");
    endtask

    task automatic test_ignore_busy();
        logic [3:0] exp_bits;
        exp_bits = 4'b0101;
        d = 4'b0101;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                d = 4'b1111;
                d_valid = 1'b1;
            end
            checks++;
            if ({sout, sframe, d_ready} !== {exp_bits[3 - i], 1'b1, (i == 3)}) begin
                failures++;
                $display("FAIL ignore bit%0d: got sout/sframe/d_ready=%b expected %b", i,
                         {sout, sframe, d_ready}, {exp_bits[3 - i], 1'b1, (i == 3)});
            end
            step();
        end
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sframe, done} !== {1'b1, 1'b1, (i == 3)}) begin
                failures++;
                $display("FAIL ignore_next bit%0d: got sout/sframe/done=%b expected %b", i,
                         {sout, sframe, done}, {1'b1, 1'b1, (i == 3)});
            end
            step();
        end
        check_idle("ignore_end");
    endtask

    task automatic test_reset_abort();
        logic [3:0] exp_bits;
        d = 4'b1001;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        checks++;
        if ({sout, sframe} !== 2'b11) begin
            failures++;
            $display("FAIL abort bit0: got sout/sframe=%b expected 11", {sout, sframe});
        end
        step();
        checks++;
        if ({sout, sframe} !== 2'b01) begin
            failures++;
            $display("FAIL abort bit1: got sout/sframe=%b expected 01", {sout, sframe});
        end
        reset = 1'b1;
        step();
        check_idle("abort_reset");
        reset = 1'b0;
        step();
        check_idle("abort_release");
        exp_bits = 4'b0110;
        d = 4'b0110;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout, sframe, done} !== {exp_bits[3 - i], 1'b1, (i == 3)}) begin
                failures++;
                $display("FAIL fresh bit%0d: got sout/sframe/done=%b expected %b", i,
                         {sout, sframe, done}, {exp_bits[3 - i], 1'b1, (i == 3)});
            end
            step();
        end
        check_idle("fresh_end");
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_seq;
        exp_seq = 4'b1100;
        d2 = 4'b0011;
        d_valid2 = 1'b1;
        step();
        d_valid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({sout2, sframe2, done2} !== {exp_seq[3 - i], 1'b1, (i == 3)}) begin
                failures++;
                $display("FAIL lsb bit%0d: got sout/sframe/done=%b expected %b", i,
                         {sout2, sframe2, done2}, {exp_seq[3 - i], 1'b1, (i == 3)});
            end
            step();
        end
        checks++;
        if ({sout2, sframe2, done2, busy2, d_ready2} !== 5'b10001) begin
            failures++;
            $display("FAIL lsb_idle: got %b expected 10001",
                     {sout2, sframe2, done2, busy2, d_ready2});
        end
    endtask

    initial begin
        reset    = 1'b1;
        d_valid  = 1'b0;
        d        = 4'b0000;
        d_valid2 = 1'b0;
        d2       = 4'b0000;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
